// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
//   ID->EX pipeline register with integrated hazard control.
//   - Latches the decoder control bundle and register specifiers into EX.
//   - Detects load-use hazards against the instruction already in EX and
//     inserts a single bubble while stalling IF/ID.
//   - Holds all stage state while a multi-cycle EX operation is busy.
//   - Squashes the ID instruction on a branch/jump flush.  A flush that
//     arrives during a hold is remembered and applied once the hold ends.
//   Stage registers update on the falling edge of CLK and are cleared
//   asynchronously by RSTn (active low).
//
//   Optional build macro: HAZARD_STATS_EN
//     When defined, adds BubbleCntOut / HoldCntOut statistics counters
//     (CNT_W bits each, wrapping).  Stage behaviour is identical either way.
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ValidIn,
    input  logic [2:0]       AluOpIn,
    input  logic             Alu1SrcIn,
    input  logic             Alu2SrcIn,
    input  logic [1:0]       RegDstIn,
    input  logic [2:0]       ExtSelIn,
    input  logic             SignIn,
    input  logic [1:0]       DigitIn,
    input  logic             DataWrIn,
    input  logic             immresIn,
    input  logic             RegWrIn,
    input  logic             MemRdIn,
    input  logic [REG_W-1:0] RsIn,
    input  logic [REG_W-1:0] RtIn,
    input  logic [REG_W-1:0] RdIn,
    input  logic             ExBusyIn,
    input  logic             FlushIn,
    output logic [2:0]       AluOpOut,
    output logic             Alu1SrcOut,
    output logic             Alu2SrcOut,
    output logic [1:0]       RegDstOut,
    output logic [2:0]       ExtSelOut,
    output logic             SignOut,
    output logic [1:0]       DigitOut,
    output logic             DataWrOut,
    output logic             immresOut,
    output logic             RegWrOut,
    output logic             MemRdOut,
    output logic [REG_W-1:0] RsOut,
    output logic [REG_W-1:0] RtOut,
    output logic [REG_W-1:0] RdOut,
    output logic             ValidOut,
    output logic             StallOut,
    output logic             FlushPendOut
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] BubbleCntOut,
    output logic [CNT_W-1:0] HoldCntOut
`endif
);

    // Contents of the EX-side stage register.
    typedef struct packed {
        logic             valid;
        logic [2:0]       alu_op;
        logic             alu1_src;
        logic             alu2_src;
        logic [1:0]       reg_dst;
        logic [2:0]       ext_sel;
        logic             sign;
        logic [1:0]       digit;
        logic             data_wr;
        logic             immres;
        logic             reg_wr;
        logic             mem_rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } stage_t;

    // What the stage does at the next falling edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } action_t;

    stage_t  stage_r;
    stage_t  stage_nxt_s;
    stage_t  load_s;
    logic    flush_pend_r;
    logic    flush_pend_nxt_s;
    logic    lu_s;
    logic    eff_flush_s;
    logic    stall_s;
    action_t action_s;

    // Load-use hazard: the EX load's destination feeds a source of the ID instruction (r0 excluded).
    always_comb begin
        lu_s = ValidIn & stage_r.valid & stage_r.mem_rd & stage_r.reg_wr &
               (stage_r.rd != {REG_W{1'b0}}) &
               ((stage_r.rd == RsIn) | (stage_r.rd == RtIn));
    end

    // Flush is effective either when requested now or when deferred from a hold.
    always_comb begin
        eff_flush_s = FlushIn | flush_pend_r;
    end

    // Stall IF/ID while EX is busy, or on a load-use hazard unless a flush redirects fetch.
    always_comb begin
        stall_s = ExBusyIn | (lu_s & ~eff_flush_s);
    end

    // Priority select of the stage action: hold > flush bubble > hazard bubble > load.
    always_comb begin
        action_s = ACT_LOAD;
        if (ExBusyIn) begin
            action_s = ACT_HOLD;
        end else if (eff_flush_s) begin
            action_s = ACT_BUBBLE;
        end else if (lu_s) begin
            action_s = ACT_BUBBLE;
        end else begin
            action_s = ACT_LOAD;
        end
    end

    // Assemble the incoming instruction; an invalid slot never carries write/read enables.
    always_comb begin
        load_s          = '0;
        load_s.valid    = ValidIn;
        load_s.alu_op   = AluOpIn;
        load_s.alu1_src = Alu1SrcIn;
        load_s.alu2_src = Alu2SrcIn;
        load_s.reg_dst  = RegDstIn;
        load_s.ext_sel  = ExtSelIn;
        load_s.sign     = SignIn;
        load_s.digit    = DigitIn;
        load_s.immres   = immresIn;
        load_s.rs       = RsIn;
        load_s.rt       = RtIn;
        load_s.rd       = RdIn;
        if (ValidIn) begin
            load_s.data_wr = DataWrIn;
            load_s.reg_wr  = RegWrIn;
            load_s.mem_rd  = MemRdIn;
        end else begin
            load_s.data_wr = 1'b0;
            load_s.reg_wr  = 1'b0;
            load_s.mem_rd  = 1'b0;
        end
    end

    // Next stage contents and deferred-flush flag for the selected action.
    always_comb begin
        stage_nxt_s      = stage_r;
        flush_pend_nxt_s = flush_pend_r;
        case (action_s)
            ACT_HOLD: begin
                stage_nxt_s = stage_r;
                if (FlushIn) begin
                    flush_pend_nxt_s = 1'b1;
                end else begin
                    flush_pend_nxt_s = flush_pend_r;
                end
            end
            ACT_BUBBLE: begin
                stage_nxt_s      = '0;
                flush_pend_nxt_s = 1'b0;
            end
            ACT_LOAD: begin
                stage_nxt_s      = load_s;
                flush_pend_nxt_s = flush_pend_r;
            end
            default: begin
                stage_nxt_s      = '0;
                flush_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Stage register: falling-edge update, asynchronous clear discards any held instruction.
    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stage_r      <= '0;
            flush_pend_r <= 1'b0;
        end else begin
            stage_r      <= stage_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] hold_cnt_r;

    // Statistics: count bubble edges and hold edges, wrapping at 2^CNT_W.
    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            hold_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (action_s)
                ACT_BUBBLE: bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                ACT_HOLD:   hold_cnt_r   <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                default: begin
                    bubble_cnt_r <= bubble_cnt_r;
                    hold_cnt_r   <= hold_cnt_r;
                end
            endcase
        end
    end

    assign BubbleCntOut = bubble_cnt_r;
    assign HoldCntOut   = hold_cnt_r;
`endif

    assign ValidOut     = stage_r.valid;
    assign AluOpOut     = stage_r.alu_op;
    assign Alu1SrcOut   = stage_r.alu1_src;
    assign Alu2SrcOut   = stage_r.alu2_src;
    assign RegDstOut    = stage_r.reg_dst;
    assign ExtSelOut    = stage_r.ext_sel;
    assign SignOut      = stage_r.sign;
    assign DigitOut     = stage_r.digit;
    assign DataWrOut    = stage_r.data_wr;
    assign immresOut    = stage_r.immres;
    assign RegWrOut     = stage_r.reg_wr;
    assign MemRdOut     = stage_r.mem_rd;
    assign RsOut        = stage_r.rs;
    assign RtOut        = stage_r.rt;
    assign RdOut        = stage_r.rd;
    assign FlushPendOut = flush_pend_r;
    assign StallOut     = stall_s;

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID→EX pipeline stage with integrated hazard control. It latches the decoder's control bundle and register specifiers into the EX stage. It also detects load-use hazards against the instruction already in EX and inserts bubbles. It holds while a multi-cycle EX operation is busy, squashes on branch flush, and drives the stall line back to IF/ID.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, width of optional statistics counters

Ports:
CLK  in  1  pipeline clock; stage registers update on negedge CLK
RSTn  in  1  asynchronous active-low reset
ValidIn  in  1  ID holds a real instruction
AluOpIn  in  3  ALU operation
Alu1SrcIn  in  1  ALU port-1 select
Alu2SrcIn  in  1  ALU port-2 select
RegDstIn  in  2  rd data source
ExtSelIn  in  3  immediate assembly mode
SignIn  in  1  immediate sign-extend
DigitIn  in  2  load/store width
DataWrIn  in  1  memory write enable
immresIn  in  1  rd takes immediate directly
RegWrIn  in  1  instruction writes rd
MemRdIn  in  1  instruction is a load
RsIn, RtIn, RdIn  in  REG_W each  register specifiers
ExBusyIn  in  1  EX multi-cycle op not finished
FlushIn  in  1  branch/jump taken in EX; squash ID instruction
(each control input X)In → X-Out  out  same width  registered copy (AluOpOut … immresOut, RegWrOut, MemRdOut, RsOut, RtOut, RdOut)
ValidOut  out  1  EX holds a real instruction
StallOut  out  1  combinational; IF/ID must hold when 1
FlushPendOut  out  1  deferred flush pending

Behaviour:
- Reset (RSTn=0, async, any time): all outputs 0, FlushPend=0. Mid-hold reset discards the held instruction.
- Hazard term (combinational): LU = ValidIn & ValidOut & MemRdOut & RegWrOut & (RdOut≠0) & ((RdOut==RsIn)|(RdOut==RtIn)).
- Effective flush: F = FlushIn | FlushPend.
- StallOut = ExBusyIn | (LU & ~F).
- Update at each negedge CLK, priority high→low:
  1. ExBusyIn=1: HOLD. All stage registers keep their values. If FlushIn=1, set FlushPend=1.
  2. F=1: BUBBLE. ValidOut, RegWrOut, MemRdOut and DataWrOut are 0. All other fields are 0. FlushPend is cleared.
  3. LU=1: BUBBLE, same as case 2. The ID instruction stays in ID because StallOut=1, and it advances at the next edge.
  4. Otherwise: LOAD all inputs. ValidOut=ValidIn.
- A bubble never asserts any write or read enable. When ValidIn=0, LOAD still copies the fields, but RegWrOut, MemRdOut and DataWrOut are forced to 0.
- Latency: one negedge from ID to EX. A load-use case costs exactly one bubble.
- Back-to-back loads with a dependency: each dependent instruction takes one bubble. No double bubble.
- Register 0 never causes a hazard.
- Simultaneous LU and F: the flush wins. StallOut=0 so that IF can redirect.
- Simultaneous ExBusyIn and LU: HOLD only. LU is re-evaluated after busy falls.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs BubbleCntOut[CNT_W] and HoldCntOut[CNT_W].
  - BubbleCntOut increments on every edge where case 2 or case 3 loads a bubble.
  - HoldCntOut increments on every edge where case 1 applies.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: the ports and logic are absent. Stage behaviour is identical in both builds.

Test Plan:
- Reset mid-stream: load AluOpIn=3'b101, DataWrIn=1, then drop RSTn between edges → all outputs 0 immediately, before the next negedge.
- Load-use: EX holds load with RdOut=5, RegWrOut=1; ID has RsIn=5 → StallOut=1, next edge ValidOut=0 and DataWrOut=0; following edge loads the ID instruction with RsOut=5.
- No hazard on r0: EX load with RdOut=0, ID RsIn=0 → StallOut=0, normal load.
- Multi-cycle hold: ExBusyIn=1 for 3 cycles → outputs unchanged for 3 edges, StallOut=1; FlushIn pulse in cycle 2 → FlushPendOut=1; after busy drops, next edge loads a bubble and FlushPendOut returns to 0.
- Flush beats hazard: LU condition and FlushIn=1 together → StallOut=0, bubble loaded.
- HAZARD_STATS_EN build: 2 load-use bubbles + 1 flush + 4 hold cycles → BubbleCntOut=3, HoldCntOut=4; with CNT_W=2, the 5th bubble wraps the counter to 1.
